// File: rtl/hc_sr04_echo_emu.sv
// rtl/hc_sr04_echo_emu.sv - HC-SR04 sensor emulator: trigger watcher, echo pulse generator, register block
`timescale 1ns/1ps
module hc_sr04_echo_emu #(
  parameter int CLK_FREQ    = 25000000,
  parameter int MIN_TRIG_US = 10,
  parameter int BURST_US    = 200,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 60
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  input  logic        trigger,
  output logic        echo
);
  localparam int DIV = CLK_FREQ / 1000000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_BURST, S_ECHO, S_HOLDOFF} state_t;

  state_t      state, state_next;
  logic [PW-1:0] pre_cnt;
  logic        tick;
  logic        trig_s1, trig_s2, trig_d;
  logic        rise, fall;
  logic [15:0] cnt, cnt_next;
  logic [15:0] echo_us, snap, last_trig, valid_cnt;
  logic [7:0]  short_cnt;
  logic        enable, echo_next;
  logic        latch_w, inc_short, inc_valid, take_snap;
  logic        reg_wr, reg_rd, ctrl_clr;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], d_in[31:16]};
  assign tick     = (pre_cnt == PW'(DIV - 1));
  assign rise     = trig_s2 & ~trig_d;
  assign fall     = ~trig_s2 & trig_d;
  assign reg_wr   = cs & wr;
  assign reg_rd   = cs & rd;
  assign ctrl_clr = reg_wr && (addr[3:2] == 2'd1) && !d_in[0];

  always_comb begin
    state_next = state;
    echo_next  = echo;
    cnt_next   = cnt;
    latch_w    = 1'b0;
    inc_short  = 1'b0;
    inc_valid  = 1'b0;
    take_snap  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (rise && enable) state_next = S_TRIG;
      end
      S_TRIG: begin
        if (fall) begin
          latch_w  = 1'b1;
          cnt_next = '0;
          if (cnt < 16'(MIN_TRIG_US)) begin
            inc_short  = 1'b1;
            state_next = S_IDLE;
          end else begin
            inc_valid  = 1'b1;
            take_snap  = 1'b1;
            state_next = S_BURST;
          end
        end else if (tick && cnt != 16'hFFFF) begin
          cnt_next = cnt + 16'd1;
        end
      end
      S_BURST: if (tick) begin
        if (cnt == 16'(BURST_US - 1)) begin
          cnt_next   = '0;
          echo_next  = 1'b1;
          state_next = S_ECHO;
        end else cnt_next = cnt + 16'd1;
      end
      S_ECHO: if (tick) begin
        if (cnt == snap - 16'd1) begin
          cnt_next   = '0;
          echo_next  = 1'b0;
          state_next = S_HOLDOFF;
        end else cnt_next = cnt + 16'd1;
      end
      S_HOLDOFF: if (tick) begin
        if (cnt == 16'(HOLDOFF_US - 1)) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end else cnt_next = cnt + 16'd1;
      end
      default: state_next = S_IDLE;
    endcase
    // Disabling aborts any job in flight, including one being written off this cycle
    if (!enable || ctrl_clr) begin
      state_next = S_IDLE;
      echo_next  = 1'b0;
      cnt_next   = '0;
      latch_w    = 1'b0;
      inc_short  = 1'b0;
      inc_valid  = 1'b0;
      take_snap  = 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr[3:2])
      2'd0: rd_data = {16'd0, echo_us};
      2'd1: rd_data = {31'd0, enable};
      2'd2: rd_data = {valid_cnt, short_cnt, 6'd0, echo, state != S_IDLE};
      default: rd_data = {16'd0, last_trig};
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      echo      <= 1'b0;
      cnt       <= '0;
      pre_cnt   <= '0;
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_d    <= 1'b0;
      echo_us   <= '0;
      enable    <= 1'b0;
      snap      <= '0;
      last_trig <= '0;
      short_cnt <= '0;
      valid_cnt <= '0;
      d_out     <= '0;
    end else begin
      state   <= state_next;
      echo    <= echo_next;
      cnt     <= cnt_next;
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      trig_s1 <= trigger;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
      if (latch_w) last_trig <= cnt;
      if (inc_short && short_cnt != 8'hFF) short_cnt <= short_cnt + 8'd1;
      if (inc_valid) valid_cnt <= valid_cnt + 16'd1;
      if (take_snap) snap <= (echo_us == 16'd0) ? 16'(TIMEOUT_US) : echo_us;
      if (reg_wr) begin
        case (addr[3:2])
          2'd0: echo_us <= d_in[15:0];
          2'd1: enable  <= d_in[0];
          default: ;
        endcase
      end
      if (reg_rd) d_out <= rd_data;
    end
  end
endmodule

// File: tb/tb_hc_sr04_echo_emu.sv
// tb/tb_hc_sr04_echo_emu.sv - directed bench for hc_sr04_echo_emu (4 cycles/us, scaled delays)
`timescale 1ns/1ps
module tb_hc_sr04_echo_emu;
  localparam int CPU     = 4;
  localparam int BURST   = 20;
  localparam int TIMEOUT = 300;
  localparam int HOLD    = 6;
  localparam int LIMIT   = 3000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] d_in = '0;
  logic        cs = 1'b0;
  logic [31:0] addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] d_out;
  logic        trigger = 1'b0;
  logic        echo;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        do_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  hc_sr04_echo_emu #(
    .CLK_FREQ(CPU * 1000000), .MIN_TRIG_US(10), .BURST_US(BURST),
    .TIMEOUT_US(TIMEOUT), .HOLDOFF_US(HOLD)
  ) dut (
    .clk(clk), .resetn(resetn), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .trigger(trigger), .echo(echo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    d = d_out;
  endtask

  task automatic pulse(input int us);
    @(negedge clk);
    trigger = 1'b1;
    repeat (us * CPU) @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_rise(output int t);
    t = 0;
    while (!echo && t < LIMIT) begin @(negedge clk); t++; end
  endtask

  task automatic wait_fall(output int t);
    t = 0;
    while (echo && t < LIMIT) begin @(negedge clk); t++; end
  endtask

  logic [31:0] r;
  int t_rise, t_high, seen;

  initial begin
    vecs[0] = '{1'b0, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 32'h4, 32'h0, 32'h0};
    vecs[2] = '{1'b0, 32'h8, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 32'hC, 32'h0, 32'h0};
    vecs[4] = '{1'b1, 32'h4, 32'hFFFFFFFF, 32'h1};
    vecs[5] = '{1'b1, 32'h0, 32'hFFFFFFFF, 32'h0000FFFF};
    vecs[6] = '{1'b1, 32'h0, 32'h12345678, 32'h00005678};
    vecs[7] = '{1'b1, 32'hC, 32'h0000FFFF, 32'h0};
    vecs[8] = '{1'b1, 32'h8, 32'hFFFFFFFF, 32'h0};
    vecs[9] = '{1'b1, 32'h4, 32'h0, 32'h0};

    repeat (3) @(negedge clk);
    check("reset_echo", {31'd0, echo}, 32'd0);
    check("reset_dout", d_out, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, r);
      check($sformatf("vec%0d", i), r, vecs[i].exp);
    end

    // Basic 58 us echo from a 12 us trigger
    bus_write(32'h0, 32'd58);
    bus_write(32'h4, 32'h1);
    pulse(12);
    wait_rise(t_rise);
    check_range("burst_delay", t_rise, BURST * CPU - 8, BURST * CPU + 8);
    wait_fall(t_high);
    check_range("echo_width_58", t_high, 58 * CPU - 8, 58 * CPU + 8);
    bus_read(32'hC, r);
    check_range("last_trig_12", int'(r), 11, 13);
    repeat (HOLD * CPU + 16) @(negedge clk);
    bus_read(32'h8, r);
    check("status_after_first", r, 32'h00010000);

    // Short trigger
    pulse(5);
    seen = 0;
    repeat (150) begin @(negedge clk); if (echo) seen++; end
    check("short_no_echo", seen, 0);
    bus_read(32'h8, r);
    check("status_short", r, 32'h00010100);
    bus_read(32'hC, r);
    check_range("last_trig_5", int'(r), 4, 6);

    // ECHO_US=0 uses timeout width
    bus_write(32'h0, 32'd0);
    pulse(12);
    wait_rise(t_rise);
    wait_fall(t_high);
    check_range("echo_timeout", t_high, TIMEOUT * CPU - 8, TIMEOUT * CPU + 8);
    repeat (HOLD * CPU + 16) @(negedge clk);

    // Rewrite during burst, retrigger during echo
    bus_write(32'h0, 32'd58);
    pulse(12);
    repeat (20) @(negedge clk);
    bus_write(32'h0, 32'd100);
    wait_rise(t_rise);
    t_high = 0;
    trigger = 1'b1;
    repeat (12 * CPU) begin @(negedge clk); t_high++; end
    trigger = 1'b0;
    while (echo && t_high < LIMIT) begin @(negedge clk); t_high++; end
    check_range("echo_inflight_58", t_high, 58 * CPU - 8, 58 * CPU + 8);
    repeat (HOLD * CPU + 16) @(negedge clk);
    bus_read(32'h8, r);
    check("status_ignored_retrig", r, 32'h00030100);
    pulse(12);
    wait_rise(t_rise);
    wait_fall(t_high);
    check_range("echo_next_100", t_high, 100 * CPU - 8, 100 * CPU + 8);
    repeat (HOLD * CPU + 16) @(negedge clk);

    // Disable mid-echo
    pulse(12);
    wait_rise(t_rise);
    check("echo_rose_e", {31'd0, echo}, 32'd1);
    repeat (20) @(negedge clk);
    bus_read(32'h8, r);
    check("status_in_echo", r, 32'h00050103);
    bus_write(32'h4, 32'h0);
    check("disable_echo_low", {31'd0, echo}, 32'd0);
    bus_read(32'h8, r);
    check("disable_status", r, 32'h00050100);

    // Async reset mid-echo
    bus_write(32'h4, 32'h1);
    pulse(12);
    wait_rise(t_rise);
    check("echo_rose_f", {31'd0, echo}, 32'd1);
    repeat (20) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check("async_reset_echo", {31'd0, echo}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bus_read(32'h0, r);
    check("post_reset_echo_us", r, 32'h0);
    bus_read(32'h4, r);
    check("post_reset_ctrl", r, 32'h0);
    bus_read(32'h8, r);
    check("post_reset_status", r, 32'h0);
    bus_read(32'hC, r);
    check("post_reset_last", r, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
